// File: rtl/ads_scan_ctrl_if.sv
// SPI frame handshake between the scan sequencer (master side) and the SPI engine (slave side).
interface ads_scan_ctrl_if;
  logic        spi_start;
  logic [15:0] spi_tx_data;
  logic        spi_done;
  logic [15:0] spi_rx_data;

  modport master (output spi_start, spi_tx_data, input spi_done, spi_rx_data);
  modport slave  (input spi_start, spi_tx_data, output spi_done, spi_rx_data);
endinterface

// File: rtl/ads_scan_ctrl.sv
// ADS SPI scan sequencer: round-robins enabled channels, one config/read frame per slot,
// and publishes each conversion tagged with the channel configured one frame earlier.
module ads_scan_ctrl #(
  parameter logic [15:0] CFG_BASE = 16'h4183,
  parameter int          GAP      = 1000,
  parameter int          WARMUP   = 6,
  parameter int          TIMEOUT  = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_en,
  input  logic [3:0]      ch_mask,
  ads_scan_ctrl_if.master spi_bus,
  output logic [15:0]     sample_data,
  output logic [1:0]      sample_ch,
  output logic            sample_valid,
  output logic [15:0]     pkg_num,
  output logic            timeout_err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_START, S_BUSY, S_PUBLISH} state_t;

  state_t        state;
  logic [1:0]    cur_ch;
  logic [1:0]    prev_ch;
  logic          prev_vld;
  logic          first_slot;
  logic          scan_en_d;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;

  logic [1:0]    search_base;
  logic [1:0]    cand;
  logic [1:0]    nxt_ch;
  logic          found;

  // Starting one position "before" bit 0 makes the first slot pick the lowest enabled channel.
  assign search_base = first_slot ? 2'd3 : cur_ch;

  always_comb begin
    nxt_ch = cur_ch;
    found  = 1'b0;
    cand   = search_base;
    for (int k = 1; k <= 4; k++) begin
      cand = search_base + 2'(k);
      if (!found && ch_mask[cand]) begin
        nxt_ch = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      cur_ch              <= 2'd0;
      prev_ch             <= 2'd0;
      prev_vld            <= 1'b0;
      first_slot          <= 1'b0;
      scan_en_d           <= 1'b0;
      gap_cnt             <= '0;
      tmo_cnt             <= '0;
      spi_bus.spi_start   <= 1'b0;
      spi_bus.spi_tx_data <= 16'd0;
      sample_data         <= 16'd0;
      sample_ch           <= 2'd0;
      sample_valid        <= 1'b0;
      pkg_num             <= 16'd0;
      timeout_err         <= 1'b0;
    end else begin
      scan_en_d         <= scan_en;
      spi_bus.spi_start <= 1'b0;
      sample_valid      <= 1'b0;
      // A falling scan_en acknowledges a fault; a timeout on the same edge still wins below.
      if (scan_en_d && !scan_en) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (scan_en && ch_mask != 4'd0 && !timeout_err) begin
            state      <= S_GAP;
            gap_cnt    <= '0;
            first_slot <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            gap_cnt <= '0;
            if (!scan_en || ch_mask == 4'd0) begin
              state    <= S_IDLE;
              pkg_num  <= 16'd0;
              prev_vld <= 1'b0;
            end else begin
              state               <= S_START;
              cur_ch              <= nxt_ch;
              first_slot          <= 1'b0;
              spi_bus.spi_start   <= 1'b1;
              spi_bus.spi_tx_data <= {CFG_BASE[15], 1'b1, nxt_ch, CFG_BASE[11:0]};
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_START: begin
          state   <= S_BUSY;
          tmo_cnt <= '0;
        end
        S_BUSY: begin
          // The sample is published on the done edge so it appears in the PUBLISH cycle.
          if (spi_bus.spi_done) begin
            state <= S_PUBLISH;
            if (prev_vld && pkg_num >= 16'(WARMUP)) begin
              sample_valid <= 1'b1;
              sample_data  <= spi_bus.spi_rx_data;
              sample_ch    <= prev_ch;
            end
            if (pkg_num != 16'hFFFF) begin
              pkg_num <= pkg_num + 16'd1;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 2)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            pkg_num     <= 16'd0;
            prev_vld    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_PUBLISH: begin
          prev_ch  <= cur_ch;
          prev_vld <= 1'b1;
          state    <= S_GAP;
          gap_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
